// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- memory-access stage of a five-stage MIPS-style pipeline.
//
// The stage accepts one instruction from the execute stage. It captures the
// synchronous SRAM read word, which is valid only in the first cycle after
// acceptance. It then aligns and extends that word for LW/LH/LHU/LB/LBU/LWL/LWR
// and passes the result to the writeback stage.
//
// Ports
//   clk              in   rising-edge clock
//   reset            in   asynchronous, active-high reset
//   ws_allowin       in   writeback stage can accept
//   ms_allowin       out  this stage can accept
//   es_to_ms_valid   in   upstream payload valid
//   es_to_ms_bus     in   {rt_value, res_from_mem, gr_we, dest, alu_result, pc}
//   es_load_mem_bus  in   {ld_width, ld_unsigned, ld_lr, addr_lo}
//   data_sram_rdata  in   SRAM read data, valid the cycle after the EXE address
//   ms_to_ws_valid   out  payload valid towards writeback
//   ms_to_ws_bus     out  {gr_we, dest, final_result, pc}
//   ms_write_reg     out  valid register write in this stage (forwarding)
//   ms_reg_dest      out  destination register of this stage (forwarding)
//   ms_to_ds_bus     out  final_result (forwarding)
// ---------------------------------------------------------------------------
module mem_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ws_allowin,
    output logic         ms_allowin,
    input  logic         es_to_ms_valid,
    input  logic [102:0] es_to_ms_bus,
    input  logic [6:0]   es_load_mem_bus,
    input  logic [31:0]  data_sram_rdata,
    output logic         ms_to_ws_valid,
    output logic [69:0]  ms_to_ws_bus,
    output logic         ms_write_reg,
    output logic [4:0]   ms_reg_dest,
    output logic [31:0]  ms_to_ds_bus
);

    logic         ms_valid;
    logic         ms_ready_go;
    logic         accept;
    logic         first_cycle;
    logic [31:0]  rdata_buf;
    logic [102:0] bus_r;
    logic [6:0]   ld_r;

    // Unpacked payload fields
    logic [31:0] rt_value;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic [1:0]  ld_width;
    logic        ld_unsigned;
    logic [1:0]  ld_lr;
    logic [1:0]  addr_lo;

    assign {rt_value, res_from_mem, gr_we, dest, alu_result, pc} = bus_r;
    assign {ld_width, ld_unsigned, ld_lr, addr_lo}               = ld_r;

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign accept         = es_to_ms_valid && ms_allowin;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    // NOTE: the whole payload, including the read-data buffer, is cleared on
    // reset, so no stale instruction or data is visible after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid    <= 1'b0;
            first_cycle <= 1'b0;
            rdata_buf   <= 32'h0;
            bus_r       <= '0;
            ld_r        <= '0;
        end else begin
            if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;   // a bubble clears ms_valid
            end
            // The SRAM word is only present in the first cycle. Save it so a
            // stalled instruction keeps its data.
            if (first_cycle) begin
                rdata_buf <= data_sram_rdata;
            end
            first_cycle <= accept;
            if (accept) begin
                bus_r <= es_to_ms_bus;
                ld_r  <= es_load_mem_bus;
            end
        end
    end

    logic [31:0] mem_data;
    logic [31:0] load_result;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    assign mem_data = first_cycle ? data_sram_rdata : rdata_buf;

    // NOTE: every variable gets a default first, so no path can infer a latch.
    always_comb begin
        load_result = mem_data;
        half_sel    = addr_lo[1] ? mem_data[31:16] : mem_data[15:0];
        byte_sel    = 8'h0;
        case (addr_lo)
            2'd0: byte_sel = mem_data[7:0];
            2'd1: byte_sel = mem_data[15:8];
            2'd2: byte_sel = mem_data[23:16];
            2'd3: byte_sel = mem_data[31:24];
            default: byte_sel = 8'h0;
        endcase

        case (ld_width)
            2'b11: load_result = mem_data;
            2'b10: load_result = {{16{!ld_unsigned && half_sel[15]}}, half_sel};
            2'b01: load_result = {{24{!ld_unsigned && byte_sel[7]}}, byte_sel};
            2'b00: begin
                if (ld_lr == 2'b10) begin            // LWL: fill from the top
                    case (addr_lo)
                        2'd0: load_result = {mem_data[7:0],  rt_value[23:0]};
                        2'd1: load_result = {mem_data[15:0], rt_value[15:0]};
                        2'd2: load_result = {mem_data[23:0], rt_value[7:0]};
                        default: load_result = mem_data;
                    endcase
                end else if (ld_lr == 2'b01) begin   // LWR: fill from the bottom
                    case (addr_lo)
                        2'd1: load_result = {rt_value[31:24], mem_data[31:8]};
                        2'd2: load_result = {rt_value[31:16], mem_data[31:16]};
                        2'd3: load_result = {rt_value[31:8],  mem_data[31:24]};
                        default: load_result = mem_data;
                    endcase
                end
            end
            default: load_result = mem_data;
        endcase
    end

    logic [31:0] final_result;

    assign final_result = res_from_mem ? load_result : alu_result;
    assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
    assign ms_write_reg = gr_we && ms_valid;
    assign ms_reg_dest  = dest;
    assign ms_to_ds_bus = final_result;

endmodule
